// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce stimulus blocks.
package bounce_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BOUNCE = 2'd1,
      SETTLE = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // One right-shifting Galois step: feedback bit is the bit shifted out.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] shifted;
      shifted = v >> 1;
      return v[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR that free-runs every clock, with a seed strobe and a
// guard that never lets the register lock up at zero.
module bounce_lfsr
   import bounce_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = lfsr_step(state_q);
      if (seed_load) begin
         state_d = (seed == 16'h0000) ? SEED : seed;
      end
   end

   assign value = state_q;

endmodule

// File: rtl/bounce_generator.sv
// Mechanical-contact emulator: every level change on `in` becomes a burst of
// 2N pseudo-random toggles followed by a stable settle window.
module bounce_generator
   import bounce_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
   parameter int          CNT_W     = 4,
   parameter int          GAP_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in,
   input  logic             enable,
   input  logic [CNT_W-1:0] bounce_count,
   input  logic [GAP_W-1:0] max_gap,
   input  logic [GAP_W-1:0] settle,
   input  logic             seed_load,
   input  logic [15:0]      seed,
   output logic             out,
   output logic             busy,
   output logic             done
);

   localparam logic [GAP_W:0]   GAP_ONE  = (GAP_W+1)'(1);
   localparam logic [CNT_W:0]   TOG_ONE  = (CNT_W+1)'(1);
   localparam logic [GAP_W-1:0] HOLD_ONE = GAP_W'(1);

   state_e           state_q, state_d;
   logic             in_q, in_d;
   logic             out_q, out_d;
   logic             done_q, done_d;
   logic [CNT_W:0]   toggles_q, toggles_d;
   logic [GAP_W:0]   gap_cnt_q, gap_cnt_d;
   logic [GAP_W-1:0] hold_q, hold_d;

   logic [15:0]      lfsr_value;
   logic             lfsr_unused;
   logic [GAP_W:0]   gap;

   bounce_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock     (clock),
      .reset     (reset),
      .seed_load (seed_load),
      .seed      (seed),
      .value     (lfsr_value)
   );

   // Only the low GAP_W bits shape the gap; the rest just keep the sequence long.
   assign lfsr_unused = ^lfsr_value;
   assign gap = {1'b0, lfsr_value[GAP_W-1:0] & max_gap} + GAP_ONE;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         in_q      <= 1'b0;
         out_q     <= 1'b0;
         done_q    <= 1'b0;
         toggles_q <= '0;
         gap_cnt_q <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         in_q      <= in_d;
         out_q     <= out_d;
         done_q    <= done_d;
         toggles_q <= toggles_d;
         gap_cnt_q <= gap_cnt_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_d      = in;
      out_d     = out_q;
      done_d    = 1'b0;
      toggles_d = toggles_q;
      gap_cnt_d = gap_cnt_q;
      hold_d    = hold_q;

      case (state_q)
         IDLE: begin
            if (!enable) begin
               out_d = in_q;
            end else if (in_q != out_q) begin
               // First contact lands on the new level immediately.
               out_d = in_q;
               if (bounce_count == '0) begin
                  hold_d  = settle;
                  state_d = SETTLE;
               end else begin
                  toggles_d = {bounce_count, 1'b0};
                  gap_cnt_d = gap;
                  state_d   = BOUNCE;
               end
            end
         end

         BOUNCE: begin
            if (!enable) begin
               out_d   = in_q;
               state_d = IDLE;
            end else if (gap_cnt_q == GAP_ONE) begin
               out_d     = ~out_q;
               toggles_d = toggles_q - TOG_ONE;
               gap_cnt_d = gap;
               // Even toggle count means out is back on the target here.
               if (toggles_q == TOG_ONE) begin
                  hold_d  = settle;
                  state_d = SETTLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_ONE;
            end
         end

         SETTLE: begin
            if (!enable) begin
               out_d   = in_q;
               state_d = IDLE;
            end else if (hold_q <= HOLD_ONE) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               hold_d = hold_q - HOLD_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      out  = out_q;
      busy = (state_q != IDLE);
      done = done_q;
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: a per-cycle vector table for the
// deterministic cases plus hand sequences for seeded, aborted and reset bursts.
module tb_bounce_generator;

   localparam int CNT_W = 4;
   localparam int GAP_W = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             in;
   logic             enable;
   logic [CNT_W-1:0] bounce_count;
   logic [GAP_W-1:0] max_gap;
   logic [GAP_W-1:0] settle;
   logic             seed_load;
   logic [15:0]      seed;
   logic             out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   int pat [4][16];
   int pat_n [4];

   typedef struct packed {
      logic       in_v;
      logic       en;
      logic [3:0] n;
      logic [7:0] mg;
      logic [7:0] st;
      logic       e_out;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs [21];

   always #5 clock = ~clock;

   bounce_generator #(
      .LFSR_SEED (16'hACE1),
      .CNT_W     (CNT_W),
      .GAP_W     (GAP_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in           (in),
      .enable       (enable),
      .bounce_count (bounce_count),
      .max_gap      (max_gap),
      .settle       (settle),
      .seed_load    (seed_load),
      .seed         (seed),
      .out          (out),
      .busy         (busy),
      .done         (done)
   );

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic return_low();
      enable = 1'b0;
      in     = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      tick();
   endtask

   // Loads a seed, raises `in` and records every interval between transitions.
   task automatic burst_capture(input logic [15:0] s, input int idx);
      logic last;
      int   n;
      int   prev_c;
      int   bad;
      bit   got_done;
      for (int k = 0; k < 16; k++) pat[idx][k] = 0;
      seed      = s;
      seed_load = 1'b1;
      in        = 1'b1;
      tick();
      seed_load = 1'b0;
      last     = out;
      n        = 0;
      prev_c   = 0;
      got_done = 1'b0;
      for (int c = 1; c <= 600 && !got_done; c++) begin
         tick();
         if (out !== last) begin
            if (n > 0 && n <= 16) pat[idx][n-1] = c - prev_c;
            prev_c = c;
            n++;
            last = out;
         end
         if (done === 1'b1) got_done = 1'b1;
      end
      pat_n[idx] = n;
      check($sformatf("rand_done_seen_%0d", idx), 32'(got_done), 32'd1);
      check($sformatf("rand_transitions_%0d", idx), 32'(n), 32'd11);
      check($sformatf("rand_final_out_%0d", idx), 32'(out), 32'd1);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (pat[idx][k] < 1 || pat[idx][k] > 16) bad++;
      end
      check($sformatf("rand_gap_range_%0d", idx), 32'(bad), 32'd0);
   endtask

   task automatic compare_patterns(input string name, input int a, input int b);
      int diff;
      diff = 0;
      for (int k = 0; k < 10; k++) begin
         if (pat[a][k] != pat[b][k]) diff++;
      end
      check(name, 32'(diff), 32'd0);
   endtask

   initial begin
      int  cnt;
      bit  seen;
      logic [31:0] dpulses;

      // in, en, N, max_gap, settle -> out, busy, done (after the next edge)
      vecs[0]  = '{1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'd2, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{1'b1, 1'b1, 4'd2, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};

      reset        = 1'b1;
      in           = 1'b0;
      enable       = 1'b0;
      bounce_count = '0;
      max_gap      = '0;
      settle       = '0;
      seed_load    = 1'b0;
      seed         = 16'h0000;
      repeat (2) tick();
      check("reset_out", 32'(out), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      reset = 1'b0;

      // Pass-through, deterministic burst and zero-bounce vectors.
      for (int i = 0; i < 21; i++) begin
         in           = vecs[i].in_v;
         enable       = vecs[i].en;
         bounce_count = vecs[i].n;
         max_gap      = vecs[i].mg;
         settle       = vecs[i].st;
         tick();
         check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].e_out));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      end

      // Seeded random gaps: rerun repeatability and the zero-seed substitute.
      bounce_count = 4'd5;
      max_gap      = 8'h0F;
      settle       = 8'd2;
      enable       = 1'b1;
      burst_capture(16'h0001, 0);
      return_low();
      burst_capture(16'h0001, 1);
      compare_patterns("rerun_same_seed", 0, 1);
      return_low();
      burst_capture(16'h0000, 2);
      return_low();
      burst_capture(16'hACE1, 3);
      compare_patterns("zero_seed_is_ace1", 2, 3);

      // Edge during a burst: first burst finishes high, second brings it low.
      return_low();
      bounce_count = 4'd3;
      max_gap      = 8'd0;
      settle       = 8'd2;
      in = 1'b1;
      tick();
      tick();
      check("edge_burst_busy", 32'(busy), 32'd1);
      tick();
      in = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      check("edge_first_done", 32'(seen), 32'd1);
      check("edge_first_level", 32'(out), 32'd1);
      tick();
      check("edge_second_start", 32'(busy), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      check("edge_second_done", 32'(seen), 32'd1);
      check("edge_second_level", 32'(out), 32'd0);

      // Abort by dropping enable while out sits on the bounced-back level.
      tick();
      in = 1'b1;
      tick();
      tick();
      tick();
      check("abort_mid_bounce_out", 32'(out), 32'd0);
      enable = 1'b0;
      tick();
      check("abort_out", 32'(out), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      dpulses = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done !== 1'b0) dpulses++;
      end
      check("abort_no_done", dpulses, 32'd0);

      // Asynchronous reset in the middle of a settle window.
      in = 1'b0;
      repeat (3) tick();
      enable       = 1'b1;
      bounce_count = 4'd0;
      settle       = 8'd10;
      in           = 1'b1;
      tick();
      tick();
      tick();
      check("settle_before_reset_out", 32'(out), 32'd1);
      check("settle_before_reset_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_reset_out", 32'(out), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
